// File: rtl/ibq_pkg.sv
// Shared defaults, sideband layout and pointer helper for the instruction byte queue.
package ibq_pkg;

    // Per-byte sideband carried alongside each fetched byte.
    typedef struct packed {
        logic        ex_taken;
        logic        taken;
        logic [31:0] target;
        logic [31:0] pc;
        logic [3:0]  fid;
    } ibq_meta_t;

    localparam int unsigned IBQ_DEPTH   = 24;
    localparam int unsigned IBQ_FETCH_W = 8;
    localparam int unsigned IBQ_PEEK_W  = 13;
    localparam int unsigned IBQ_META_W  = $bits(ibq_meta_t);

    // Field offsets inside one META_W slice.
    localparam int unsigned META_FID_LSB      = 0;
    localparam int unsigned META_FID_W        = 4;
    localparam int unsigned META_PC_LSB       = 4;
    localparam int unsigned META_PC_W         = 32;
    localparam int unsigned META_TGT_LSB      = 36;
    localparam int unsigned META_TGT_W        = 32;
    localparam int unsigned META_TAKEN_BIT    = 68;
    localparam int unsigned META_EX_TAKEN_BIT = 69;

    // Circular pointer advance; callers guarantee p < depth and n <= depth,
    // so a single conditional subtract is enough.
    function automatic int unsigned ibq_wrap_add(input int unsigned p,
                                                 input int unsigned n,
                                                 input int unsigned depth);
        int unsigned s;
        s = p + n;
        return (s >= depth) ? (s - depth) : s;
    endfunction

endpackage

// File: rtl/ibq_rotate.sv
// Circular-store read window: PEEK_W bytes starting at head, plus one meta
// slice at head+sel_i.
//   head_i     : current head index
//   sel_i      : window lane whose meta is returned
//   mem_data_i : full byte store
//   mem_meta_i : full sideband store
//   rd_data_o  : bytes head..head+PEEK_W-1 (unmasked)
//   rd_meta_o  : meta of byte head+sel_i (unmasked)
module ibq_rotate
    import ibq_pkg::*;
#(
    parameter int unsigned DEPTH  = IBQ_DEPTH,
    parameter int unsigned PEEK_W = IBQ_PEEK_W,
    parameter int unsigned META_W = IBQ_META_W,
    parameter int unsigned PTR_W  = $clog2(DEPTH),
    parameter int unsigned SEL_W  = (PEEK_W > 1) ? $clog2(PEEK_W) : 1
) (
    input  logic [PTR_W-1:0]                  head_i,
    input  logic [SEL_W-1:0]                  sel_i,
    input  logic [DEPTH-1:0][7:0]             mem_data_i,
    input  logic [DEPTH-1:0][META_W-1:0]      mem_meta_i,
    output logic [PEEK_W-1:0][7:0]            rd_data_o,
    output logic [META_W-1:0]                 rd_meta_o
);

    logic [PTR_W-1:0] rd_idx [PEEK_W];
    logic [PTR_W-1:0] meta_idx;

    always_comb begin
        for (int unsigned i = 0; i < PEEK_W; i++) begin
            rd_idx[i]    = PTR_W'(ibq_wrap_add(32'(head_i), i, DEPTH));
            rd_data_o[i] = mem_data_i[rd_idx[i]];
        end
        meta_idx  = PTR_W'(ibq_wrap_add(32'(head_i), 32'(sel_i), DEPTH));
        rd_meta_o = mem_meta_i[meta_idx];
    end

endmodule

// File: rtl/ibyte_queue.sv
// Instruction byte queue between fetch and decode: variable-size pushes of
// up to FETCH_W bytes, variable-size pops of up to PEEK_W bytes, and a
// PEEK_W-byte window for decode.
//   CLK, reset           : clock, async active-high reset
//   push_valid/cnt/data/meta, push_ready : fetch side
//   pop_en/pop_cnt, pop_ok               : decode consume side
//   flush                : discard all bytes
//   peek_data/valid/meta : decode window (combinational from state)
//   count                : occupancy
module ibyte_queue
    import ibq_pkg::*;
#(
    parameter int unsigned DEPTH   = IBQ_DEPTH,
    parameter int unsigned FETCH_W = IBQ_FETCH_W,
    parameter int unsigned PEEK_W  = IBQ_PEEK_W,
    parameter int unsigned META_W  = IBQ_META_W
) (
    input  logic                             CLK,
    input  logic                             reset,
    input  logic                             push_valid,
    input  logic [$clog2(FETCH_W+1)-1:0]     push_cnt,
    input  logic [FETCH_W*8-1:0]             push_data,
    input  logic [FETCH_W*META_W-1:0]        push_meta,
    output logic                             push_ready,
    input  logic                             pop_en,
    input  logic [$clog2(PEEK_W+1)-1:0]      pop_cnt,
    output logic                             pop_ok,
    input  logic                             flush,
    output logic [PEEK_W*8-1:0]              peek_data,
    output logic [PEEK_W-1:0]                peek_valid,
    output logic [META_W-1:0]                peek_meta,
    output logic [$clog2(DEPTH+1)-1:0]       count
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH+1);
    localparam int unsigned PCW    = $clog2(FETCH_W+1);
    localparam int unsigned SEL_W  = (PEEK_W > 1) ? $clog2(PEEK_W) : 1;

    if (DEPTH < FETCH_W + PEEK_W) begin : g_depth_check
        $error("ibyte_queue: DEPTH must be >= FETCH_W + PEEK_W");
    end

    logic [PTR_W-1:0]             head_q, head_d;
    logic [PTR_W-1:0]             tail_q, tail_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [DEPTH-1:0][7:0]        data_q;
    logic [DEPTH-1:0][META_W-1:0] meta_q;

    logic [PCW-1:0]               push_n;
    logic                         push_acc;
    logic                         pop_acc;
    logic [PTR_W-1:0]             lane_idx [FETCH_W];
    logic [SEL_W-1:0]             meta_sel;
    logic [PEEK_W-1:0][7:0]       rd_data;
    logic [META_W-1:0]            rd_meta;

    // Handshakes; ready looks only at current occupancy.
    always_comb begin
        push_n     = (32'(push_cnt) > FETCH_W) ? PCW'(FETCH_W) : push_cnt;
        push_ready = (32'(count_q) + FETCH_W <= DEPTH);
        pop_ok     = (pop_cnt != '0) && (32'(pop_cnt) <= 32'(count_q));
        push_acc   = push_valid && push_ready && !flush;
        pop_acc    = pop_en && pop_ok && !flush;
    end

    // Pointer / occupancy next state; flush wins over both transfers.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop_acc) begin
                head_d = PTR_W'(ibq_wrap_add(32'(head_q), 32'(pop_cnt), DEPTH));
            end
            if (push_acc) begin
                tail_d = PTR_W'(ibq_wrap_add(32'(tail_q), 32'(push_n), DEPTH));
            end
            count_d = CNT_W'(32'(count_q)
                             + (push_acc ? 32'(push_n) : 32'd0)
                             - (pop_acc  ? 32'(pop_cnt) : 32'd0));
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Write-lane steering: lane i lands at tail+i.
    always_comb begin
        for (int unsigned i = 0; i < FETCH_W; i++) begin
            lane_idx[i] = PTR_W'(ibq_wrap_add(32'(tail_q), i, DEPTH));
        end
    end

    // Storage is intentionally not reset; invalid lanes are masked on output.
    always_ff @(posedge CLK) begin
        for (int unsigned i = 0; i < FETCH_W; i++) begin
            if (push_acc && (i < 32'(push_n))) begin
                data_q[lane_idx[i]] <= push_data[8*i +: 8];
                meta_q[lane_idx[i]] <= push_meta[META_W*i +: META_W];
            end
        end
    end

    // Meta lane: pop_cnt-1, lane 0 when pop_cnt is 0, clamped to the window.
    always_comb begin
        if (pop_cnt == '0) begin
            meta_sel = '0;
        end else if (32'(pop_cnt) > PEEK_W) begin
            meta_sel = SEL_W'(PEEK_W - 1);
        end else begin
            meta_sel = SEL_W'(32'(pop_cnt) - 32'd1);
        end
    end

    ibq_rotate #(
        .DEPTH  (DEPTH),
        .PEEK_W (PEEK_W),
        .META_W (META_W)
    ) u_rotate (
        .head_i     (head_q),
        .sel_i      (meta_sel),
        .mem_data_i (data_q),
        .mem_meta_i (meta_q),
        .rd_data_o  (rd_data),
        .rd_meta_o  (rd_meta)
    );

    // Mask lanes beyond occupancy so unreset storage never leaks out.
    always_comb begin
        peek_data = '0;
        for (int unsigned i = 0; i < PEEK_W; i++) begin
            peek_valid[i] = (i < 32'(count_q));
            if (peek_valid[i]) begin
                peek_data[8*i +: 8] = rd_data[i];
            end
        end
        peek_meta = peek_valid[meta_sel] ? rd_meta : '0;
        count     = count_q;
    end

endmodule

// File: tb/tb_ibyte_queue.sv
module tb_ibyte_queue;

    localparam int unsigned DEPTH   = 24;
    localparam int unsigned FETCH_W = 8;
    localparam int unsigned PEEK_W  = 13;
    localparam int unsigned META_W  = 70;

    logic                      CLK = 1'b0;
    logic                      reset;
    logic                      push_valid;
    logic [3:0]                push_cnt;
    logic [FETCH_W*8-1:0]      push_data;
    logic [FETCH_W*META_W-1:0] push_meta;
    logic                      push_ready;
    logic                      pop_en;
    logic [3:0]                pop_cnt;
    logic                      pop_ok;
    logic                      flush;
    logic [PEEK_W*8-1:0]       peek_data;
    logic [PEEK_W-1:0]         peek_valid;
    logic [META_W-1:0]         peek_meta;
    logic [4:0]                count;

    int checks = 0;
    int errors = 0;

    // Reference model: the queue contents in order, head at index 0.
    logic [7:0]        bq [$];
    logic [META_W-1:0] mq [$];
    logic [7:0]        nb;

    ibyte_queue #(
        .DEPTH(DEPTH), .FETCH_W(FETCH_W), .PEEK_W(PEEK_W), .META_W(META_W)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .push_valid (push_valid),
        .push_cnt   (push_cnt),
        .push_data  (push_data),
        .push_meta  (push_meta),
        .push_ready (push_ready),
        .pop_en     (pop_en),
        .pop_cnt    (pop_cnt),
        .pop_ok     (pop_ok),
        .flush      (flush),
        .peek_data  (peek_data),
        .peek_valid (peek_valid),
        .peek_meta  (peek_meta),
        .count      (count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model for the currently driven inputs.
    task automatic check_all(input string tag);
        int unsigned       sz;
        int unsigned       pc;
        int unsigned       sel;
        logic [PEEK_W*8-1:0] ed;
        logic [PEEK_W-1:0]   ev;
        logic [META_W-1:0]   em;
        sz = bq.size();
        pc = 32'(pop_cnt);
        ed = '0;
        ev = '0;
        for (int unsigned i = 0; i < PEEK_W; i++) begin
            if (i < sz) begin
                ed[8*i +: 8] = bq[i];
                ev[i] = 1'b1;
            end
        end
        sel = (pc == 0) ? 0 : ((pc > PEEK_W) ? PEEK_W - 1 : pc - 1);
        em  = (sel < sz) ? mq[sel] : '0;
        check({tag, "_count"}, 128'(count), 128'(sz));
        check({tag, "_push_ready"}, 128'(push_ready), 128'(DEPTH - sz >= FETCH_W));
        check({tag, "_pop_ok"}, 128'(pop_ok), 128'(pc != 0 && pc <= sz));
        check({tag, "_peek_valid"}, 128'(peek_valid), 128'(ev));
        check({tag, "_peek_data"}, 128'(peek_data), 128'(ed));
        check({tag, "_peek_meta"}, 128'(peek_meta), 128'(em));
    endtask

    // Apply one clock of the specification's rules to the model.
    task automatic model_update();
        int unsigned sz;
        int unsigned n;
        sz = bq.size();
        if (flush) begin
            bq.delete();
            mq.delete();
        end else begin
            if (pop_en && pop_cnt != 0 && 32'(pop_cnt) <= sz) begin
                repeat (int'(pop_cnt)) begin
                    void'(bq.pop_front());
                    void'(mq.pop_front());
                end
            end
            if (push_valid && (DEPTH - sz >= FETCH_W)) begin
                n = (32'(push_cnt) > FETCH_W) ? FETCH_W : 32'(push_cnt);
                for (int unsigned i = 0; i < n; i++) begin
                    bq.push_back(push_data[8*i +: 8]);
                    mq.push_back(push_meta[META_W*i +: META_W]);
                end
                nb = 8'(32'(nb) + n);
            end
        end
    endtask

    task automatic drive(input bit pv, input int unsigned pcnt, input bit pe,
                         input int unsigned ocnt, input bit fl);
        push_valid = pv;
        push_cnt   = 4'(pcnt);
        pop_en     = pe;
        pop_cnt    = 4'(ocnt);
        flush      = fl;
        for (int unsigned i = 0; i < FETCH_W; i++) begin
            push_data[8*i +: 8] = 8'(32'(nb) + i);
            push_meta[META_W*i +: META_W] = META_W'({$urandom, $urandom, $urandom});
        end
    endtask

    task automatic idle();
        push_valid = 1'b0;
        push_cnt   = '0;
        pop_en     = 1'b0;
        pop_cnt    = '0;
        flush      = 1'b0;
    endtask

    // One cycle: drive, check pre-edge outputs, advance model, clock, go idle.
    task automatic step(input string tag, input bit pv, input int unsigned pcnt,
                        input bit pe, input int unsigned ocnt, input bit fl);
        @(negedge CLK);
        drive(pv, pcnt, pe, ocnt, fl);
        #1;
        check_all(tag);
        model_update();
        @(posedge CLK);
        #1;
        idle();
    endtask

    initial begin
        logic [7:0] old5;
        idle();
        push_data = '0;
        push_meta = '0;
        nb = 8'h10;
        reset = 1'b1;
        #3;
        check_all("rst");
        @(negedge CLK);
        reset = 1'b0;

        // Single full push, sequential bytes 0x10..0x17.
        step("p8", 1, 8, 0, 0, 0);
        check("c036_count", 128'(count), 128'(8));
        check("c036_valid", 128'(peek_valid), 128'(13'h00FF));
        check("c036_byte0", 128'(peek_data[7:0]), 128'(8'h10));
        check("c036_byte7", 128'(peek_data[63:56]), 128'(8'h17));
        check("c036_ready", 128'(push_ready), 128'(1));

        // Fill past the ready threshold, then free one byte.
        step("p8b", 1, 8, 0, 0, 0);
        step("p1", 1, 1, 0, 0, 0);
        check("c037_count17", 128'(count), 128'(17));
        check("c037_ready0", 128'(push_ready), 128'(0));
        step("pop1", 0, 0, 1, 1, 0);
        check("c037_count16", 128'(count), 128'(16));
        check("c037_ready1", 128'(push_ready), 128'(1));

        // Steady push 8 / pop 5 drives both pointers around the ring.
        for (int k = 0; k < 30; k++) begin
            step("wrap", 1, 8, 1, 5, 0);
        end
        step("wrap_end", 0, 0, 0, 0, 0);

        // Simultaneous push and pop from count=10.
        step("f39", 0, 0, 0, 0, 1);
        step("f39p8", 1, 8, 0, 0, 0);
        step("f39p2", 1, 2, 0, 0, 0);
        check("c039_count10", 128'(count), 128'(10));
        old5 = bq[5];
        step("pp", 1, 8, 1, 5, 0);
        check("c039_count13", 128'(count), 128'(13));
        check("c039_byte0", 128'(peek_data[7:0]), 128'(old5));

        // Over-length pop is refused, exact-length pop empties.
        step("f40", 0, 0, 0, 0, 1);
        step("f40p5", 1, 5, 0, 0, 0);
        step("pop6", 0, 0, 1, 6, 0);
        check("c040_count5", 128'(count), 128'(5));
        step("pop5", 0, 0, 1, 5, 0);
        check("c040_count0", 128'(count), 128'(0));
        check("c040_valid0", 128'(peek_valid), 128'(0));

        // Flush beats a same-cycle push and pop.
        step("f41", 0, 0, 0, 0, 1);
        step("f41p8", 1, 8, 0, 0, 0);
        step("f41p4", 1, 4, 0, 0, 0);
        check("c041_count12", 128'(count), 128'(12));
        step("flushall", 1, 8, 1, 3, 1);
        check("c041_flush_count", 128'(count), 128'(0));
        check("c041_flush_valid", 128'(peek_valid), 128'(0));

        // Random traffic including oversized push_cnt and rare flushes.
        for (int k = 0; k < 600; k++) begin
            step("rnd", 1'($urandom_range(0, 3) != 0), $urandom_range(0, 15),
                 1'($urandom_range(0, 1)), $urandom_range(0, 13),
                 1'($urandom_range(0, 31) == 0));
        end

        // Reset mid-push discards everything; next push lands at index 0.
        step("pre_rst", 1, 8, 0, 0, 0);
        @(negedge CLK);
        drive(1, 8, 1, 2, 0);
        #1;
        reset = 1'b1;
        #1;
        bq.delete();
        mq.delete();
        check_all("rst_mid");
        check("rst_ready", 128'(push_ready), 128'(1));
        check("rst_meta", 128'(peek_meta), 128'(0));
        @(posedge CLK);
        #1;
        idle();
        @(negedge CLK);
        reset = 1'b0;
        step("post_rst", 1, 3, 0, 0, 0);
        step("post_rst_chk", 0, 0, 1, 3, 0);
        check("post_rst_count", 128'(count), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
